spk_group_sequencer: RTL

Controller that runs one time-step of membrane-potential update for a layer stored as `NUM_GROUPS` groups of 16 neurons. For each group it reads 128-bit potentials and 64-bit betas from potential memory and drives the `u_b_processor` load path to obtain decayed potentials. It hands those potentials to the integration/threshold stage, collects the 16 spike bits and integrated potentials, and drives the `u_b_processor` save path. It then writes the result back and emits the group's spikes. It sits between the layer scheduler (start/done), the potential memory and the `u_b_processor` datapath.

---
 rtl/spk_group_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spk_group_sequencer.sv
// spk_group_sequencer: steps one layer, group by group, through
// read -> decay -> integrate -> save -> write, emitting spikes per group.
module spk_group_sequencer #(
    parameter int NUM_GROUPS = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [127:0]      mem_rd_pot,
    input  logic [63:0]       mem_rd_beta,
    output logic [127:0]      mem_wr_data,
    output logic [127:0]      proc_load_pot_in,
    output logic [63:0]       proc_load_beta_in,
    input  logic [127:0]      proc_load_pot_out,
    output logic [127:0]      proc_save_pot_in,
    output logic [15:0]       proc_save_spk_in,
    input  logic [127:0]      proc_save_pot_out,
    output logic              int_req,
    output logic [127:0]      int_pot,
    input  logic              int_valid,
    input  logic [127:0]      int_pot_in,
    input  logic [15:0]       int_spk_in,
    output logic [15:0]       spk_out,
    output logic              spk_out_valid,
    output logic [ADDR_W-1:0] spk_out_group
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        DECAY,
        INT_WAIT,
        SAVE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_GROUPS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   g;
    logic [127:0]        pot_reg;
    logic [63:0]         beta_reg;
    logic [127:0]        dec_reg;
    logic [127:0]        sv_pot_reg;
    logic [15:0]         sv_spk_reg;

    // Sequencer state, group counter and per-group data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            g          <= '0;
            pot_reg    <= '0;
            beta_reg   <= '0;
            dec_reg    <= '0;
            sv_pot_reg <= '0;
            sv_spk_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        g     <= '0;
                        state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_rd_valid) begin
                        pot_reg  <= mem_rd_pot;
                        beta_reg <= mem_rd_beta;
                        state    <= DECAY;
                    end
                end
                DECAY: begin
                    dec_reg <= proc_load_pot_out;
                    state   <= INT_WAIT;
                end
                INT_WAIT: begin
                    if (int_valid) begin
                        sv_pot_reg <= int_pot_in;
                        sv_spk_reg <= int_spk_in;
                        state      <= SAVE;
                    end
                end
                SAVE: begin
                    if (g == LAST) begin
                        state <= DONE;
                    end else begin
                        g     <= g + ADDR_W'(1);
                        state <= RD_REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Controls decode only the state register; no input reaches them.
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign mem_rd_en     = (state == RD_REQ);
    assign mem_wr_en     = (state == SAVE);
    assign int_req       = (state == INT_WAIT);
    assign spk_out_valid = (state == SAVE);

    assign mem_addr      = g;
    assign spk_out_group = g;

    // Write data and spikes are only driven while the write is live.
    assign mem_wr_data = (state == SAVE) ? proc_save_pot_out : '0;
    assign spk_out     = (state == SAVE) ? sv_spk_reg : '0;

    assign proc_load_pot_in  = pot_reg;
    assign proc_load_beta_in = beta_reg;
    assign int_pot           = dec_reg;
    assign proc_save_pot_in  = sv_pot_reg;
    assign proc_save_spk_in  = sv_spk_reg;

endmodule
